// File: rtl/dut_query_slot.sv
// Slot-scheduled query engine: after a start pulse a free-running slot timer
// emits a periodic tick; a latched query N is served at the next tick seen while
// idle, sum(1..N) is accumulated serially, and the result is reported with a
// one-cycle end pulse. A sticky flag marks NUM_QUERY completed queries.
module dut_query_slot #(
  parameter int unsigned BW_QUERY_DATA = 32,
  parameter int unsigned SLOT_PERIOD   = 1024,
  parameter int unsigned NUM_QUERY     = 3
) (
  input  logic                     iClk,
  input  logic                     iRsn,
  input  logic                     iStart,
  output logic                     oSlotTick,
  input  logic                     iQueryDataEn,
  input  logic [BW_QUERY_DATA-1:0] iQueryData,
  output logic [BW_QUERY_DATA-1:0] oQueryData,
  output logic                     oQueryEnd,
  output logic                     oEnd
);

  localparam int unsigned SlotW  = (SLOT_PERIOD > 1) ? $clog2(SLOT_PERIOD) : 1;
  localparam int unsigned CountW = $clog2(NUM_QUERY + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e                   state;
  state_e                   stateNext;
  logic                     running;
  logic [SlotW-1:0]         slotCnt;
  logic                     slotTick;
  logic                     pending;
  logic [BW_QUERY_DATA-1:0] queryLatch;
  logic [BW_QUERY_DATA-1:0] acc;
  logic [BW_QUERY_DATA-1:0] cnt;
  logic [CountW-1:0]        queryCount;
  logic                     serve;
  logic                     capture;
  logic                     finish;

  assign slotTick  = running && (slotCnt == SlotW'(SLOT_PERIOD - 1));
  assign oSlotTick = slotTick;

  // Pending query is only consumed by a tick that arrives while idle.
  assign serve   = (state == StIdle) && slotTick && pending;
  assign capture = iQueryDataEn && running && !pending;
  // Last busy cycle: accumulation complete, DONE follows.
  assign finish  = (state == StBusy) && (cnt == '0);

  // Slot timer: armed by iStart, then wraps every SLOT_PERIOD cycles until reset.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      running <= 1'b0;
      slotCnt <= '0;
    end else if (!running) begin
      if (iStart) begin
        running <= 1'b1;
        slotCnt <= '0;
      end
    end else if (slotTick) begin
      slotCnt <= '0;
    end else begin
      slotCnt <= slotCnt + 1'b1;
    end
  end

  // Single-entry query buffer; new strobes are dropped while an entry is held.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      pending    <= 1'b0;
      queryLatch <= '0;
    end else if (capture) begin
      pending    <= 1'b1;
      queryLatch <= iQueryData;
    end else if (serve) begin
      pending    <= 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      state <= StIdle;
    end else begin
      state <= stateNext;
    end
  end

  // FSM next-state logic.
  always_comb begin
    stateNext = state;
    unique case (state)
      StIdle:  if (serve) stateNext = StBusy;
      StBusy:  if (cnt == '0) stateNext = StDone;
      StDone:  stateNext = StIdle;
      default: stateNext = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    oQueryEnd = (state == StDone);
  end

  // Serial accumulator: adds N, N-1, ..., 1, wrapping modulo 2^BW.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      acc <= '0;
      cnt <= '0;
    end else if (serve) begin
      acc <= '0;
      cnt <= queryLatch;
    end else if ((state == StBusy) && (cnt != '0)) begin
      acc <= acc + cnt;
      cnt <= cnt - 1'b1;
    end
  end

  // Result, completion count and sticky end flag are loaded on entry to DONE so
  // they are already valid during the oQueryEnd cycle.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      oQueryData <= '0;
      queryCount <= '0;
      oEnd       <= 1'b0;
    end else if (finish) begin
      oQueryData <= acc;
      if (queryCount < CountW'(NUM_QUERY)) begin
        queryCount <= queryCount + 1'b1;
      end
      if (queryCount == CountW'(NUM_QUERY - 1)) begin
        oEnd <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dut_query_slot.sv
// Directed bench for dut_query_slot: expected results are queued when a query is
// driven and matched against each oQueryEnd pulse; ticks and flags are checked
// every cycle against a small reference model.
module tb_dut_query_slot;

  localparam int P = 1024;

  logic        iClk = 1'b0;
  logic        iRsn = 1'b1;
  logic        iStart = 1'b0;
  logic        iQueryDataEn = 1'b0;
  logic [31:0] iQueryData = '0;
  logic        oSlotTick;
  logic [31:0] oQueryData;
  logic        oQueryEnd;
  logic        oEnd;

  dut_query_slot #(
    .BW_QUERY_DATA(32),
    .SLOT_PERIOD  (P),
    .NUM_QUERY    (3)
  ) dut (
    .iClk        (iClk),
    .iRsn        (iRsn),
    .iStart      (iStart),
    .oSlotTick   (oSlotTick),
    .iQueryDataEn(iQueryDataEn),
    .iQueryData  (iQueryData),
    .oQueryData  (oQueryData),
    .oQueryEnd   (oQueryEnd),
    .oEnd        (oEnd)
  );

  always #5 iClk = ~iClk;

  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] val;
    int          endCyc;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  bit          tbRunning = 0;
  int          tbS = 0;
  int          doneCnt = 0;
  logic        expEnd = 1'b0;
  logic [31:0] lastData = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int nextTick(input int c);
    return tbS + ((c - tbS) / P + 1) * P;
  endfunction

  function automatic logic [31:0] sumTo(input logic [31:0] n);
    longint unsigned x;
    x = n;
    return 32'((x * (x + 1)) / 2);
  endfunction

  // One clock: sample outputs 2 time units after the rising edge, then return at
  // the falling edge where the caller drives inputs.
  task automatic step();
    logic expTick;
    exp_t e;
    @(posedge iClk);
    #2;
    expTick = tbRunning && (cyc > tbS) && (((cyc - tbS) % P) == 0);
    chk("slot_tick", 32'(oSlotTick), 32'(expTick));
    if (oQueryEnd) begin
      if (sb.size() == 0) begin
        chk("unexpected_end", 32'(oQueryEnd), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("query_data", oQueryData, e.val);
        chk("end_cycle", cyc, e.endCyc);
        lastData = e.val;
        doneCnt++;
        if (doneCnt >= 3) expEnd = 1'b1;
      end
    end
    chk("data_hold", oQueryData, lastData);
    chk("end_flag", 32'(oEnd), 32'(expEnd));
    @(negedge iClk);
  endtask

  task automatic waitDone(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk("timeout", sb.size(), 0);
  endtask

  task automatic query(input logic [31:0] n, input bit served);
    if (served) sb.push_back('{sumTo(n), nextTick(cyc) + int'(n) + 2});
    iQueryDataEn = 1'b1;
    iQueryData   = n;
    step();
    iQueryDataEn = 1'b0;
    iQueryData   = $urandom;
  endtask

  task automatic startPulse();
    iStart    = 1'b1;
    tbS       = cyc;
    tbRunning = 1'b1;
    step();
    iStart = 1'b0;
  endtask

  task automatic toTick();
    while (((cyc - tbS) % P) != 0) step();
  endtask

  task automatic chkResetOutputs();
    chk("rst_slot_tick", 32'(oSlotTick), 32'd0);
    chk("rst_query_end", 32'(oQueryEnd), 32'd0);
    chk("rst_query_data", oQueryData, 32'd0);
    chk("rst_end", 32'(oEnd), 32'd0);
  endtask

  initial begin
    #1 iRsn = 1'b0;
    #1 chkResetOutputs();
    repeat (3) step();
    iRsn = 1'b1;
    repeat (2) step();

    // Query before start is dropped.
    query(32'd5, 1'b0);
    repeat (5) step();

    startPulse();
    repeat (10) step();

    query(32'd4, 1'b1);
    waitDone(1200);

    // iStart while running must not disturb tick phase.
    iStart = 1'b1;
    step();
    iStart = 1'b0;

    query(32'd30, 1'b1);
    waitDone(1200);
    query(32'd1, 1'b1);
    waitDone(1200);
    query(32'd0, 1'b1);
    waitDone(1200);

    // Second query while one is pending is dropped.
    query(32'd7, 1'b1);
    step();
    query(32'd12, 1'b0);
    waitDone(1200);

    // Query on a tick cycle waits for the following tick.
    toTick();
    query(32'd12, 1'b1);
    waitDone(2200);

    // Query captured while busy is served at the next tick.
    query(32'd20, 1'b1);
    toTick();
    repeat (3) step();
    query(32'd3, 1'b1);
    waitDone(2200);

    // Reset in the middle of a busy query aborts it.
    query(32'd30, 1'b1);
    toTick();
    repeat (3) step();
    iRsn = 1'b0;
    #1 chkResetOutputs();
    tbRunning = 1'b0;
    sb.delete();
    doneCnt  = 0;
    expEnd   = 1'b0;
    lastData = '0;
    repeat (3) step();
    iRsn = 1'b1;
    repeat (1100) step();

    // Restart after reset ticks again from the new start.
    startPulse();
    repeat (1030) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
